ant_motor_drive: RTL

- Downstream stage of the ant steering FSM. Consumes its per-cycle steering commands TL/TR/F and drives two wheel motors (differential drive).
- Each wheel gets a PWM output and a direction output.
- Duty ramps in fixed steps at PWM period boundaries (soft start/stop).
- A wheel always ramps to zero duty before its direction flips, so an H-bridge never sees a reversal under load.

---
 rtl/ant_motor_drive.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ant_motor_drive.sv
// Differential-drive motor stage: turns registered TL/TR/F steering commands into
// per-wheel PWM and direction, with ramped duty and zero-duty direction reversal.
module ant_motor_drive #(
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 4,
  parameter int DUTY_MAX  = 200,
  parameter int TURN_DUTY = 120,
  parameter int RAMP_STEP = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       TL,
  input  logic       TR,
  input  logic       F,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       moving,
  output logic       cmd_err,
  output logic [1:0] status
);

  localparam int DW       = PWM_BITS + 1;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STEP_SAT = (RAMP_STEP > (1 << PWM_BITS) - 1) ? (1 << PWM_BITS) - 1 : RAMP_STEP;
  localparam logic [DW-1:0]       STEP     = DW'(STEP_SAT);
  localparam logic [DW-1:0]       D_FULL   = DW'(DUTY_MAX);
  localparam logic [DW-1:0]       D_TURN   = DW'(TURN_DUTY);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_BRAKE  = 2'd3
  } status_t;

  // Move d toward t by at most STEP, landing exactly on t; one spare bit keeps d+STEP from wrapping.
  function automatic logic [DW-1:0] ramp_to(input logic [DW-1:0] d, input logic [DW-1:0] t);
    logic [DW-1:0] r;
    r = d;
    if (d < t)      r = ((t - d) > STEP) ? d + STEP : t;
    else if (d > t) r = ((d - t) > STEP) ? d - STEP : t;
    return r;
  endfunction

  logic [3:0]          cmd_q;
  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_l, duty_r;
  logic                tick, pend, illegal;
  logic [DW-1:0]       tgt_l, tgt_r, duty_l_n, duty_r_n;
  logic                tdir_l, tdir_r, dir_l_n, dir_r_n;
  status_t             status_q, status_n;

  assign tick    = (presc == PS_LAST);
  assign pend    = tick && (pwm_cnt == CNT_LAST);
  assign illegal = cmd_q[2] & cmd_q[1];

  // Target decode from the registered command {en,TL,TR,F}
  always_comb begin
    tgt_l  = '0;
    tgt_r  = '0;
    tdir_l = dir_l;
    tdir_r = dir_r;
    if (cmd_q[3] && !illegal) begin
      case (cmd_q[2:0])
        3'b001: begin tdir_l = 1'b1; tgt_l = D_FULL; tdir_r = 1'b1; tgt_r = D_FULL; end
        3'b100: begin tdir_l = 1'b0; tgt_l = D_TURN; tdir_r = 1'b1; tgt_r = D_TURN; end
        3'b010: begin tdir_l = 1'b1; tgt_l = D_TURN; tdir_r = 1'b0; tgt_r = D_TURN; end
        3'b101: begin tdir_l = 1'b1; tgt_l = D_TURN; tdir_r = 1'b1; tgt_r = D_FULL; end
        3'b011: begin tdir_l = 1'b1; tgt_l = D_FULL; tdir_r = 1'b1; tgt_r = D_TURN; end
        default: ;
      endcase
    end
  end

  // A wheel facing the wrong way brakes to zero first, flips direction only once stopped
  always_comb begin
    dir_l_n  = dir_l;
    dir_r_n  = dir_r;
    duty_l_n = {1'b0, duty_l};
    duty_r_n = {1'b0, duty_r};
    if (pend) begin
      if (dir_l != tdir_l) begin
        duty_l_n = ramp_to({1'b0, duty_l}, '0);
        if (duty_l == '0) dir_l_n = tdir_l;
      end else begin
        duty_l_n = ramp_to({1'b0, duty_l}, tgt_l);
      end
      if (dir_r != tdir_r) begin
        duty_r_n = ramp_to({1'b0, duty_r}, '0);
        if (duty_r == '0) dir_r_n = tdir_r;
      end else begin
        duty_r_n = ramp_to({1'b0, duty_r}, tgt_r);
      end
    end
  end

  always_comb begin
    status_n = ST_ACCEL;
    if (duty_l_n == '0 && duty_r_n == '0 && tgt_l == '0 && tgt_r == '0)
      status_n = ST_STOP;
    else if (duty_l_n == tgt_l && duty_r_n == tgt_r && dir_l_n == tdir_l && dir_r_n == tdir_r)
      status_n = ST_CRUISE;
    else if (dir_l_n != tdir_l || dir_r_n != tdir_r || duty_l_n > tgt_l || duty_r_n > tgt_r)
      status_n = ST_BRAKE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q    <= '0;
      presc    <= '0;
      pwm_cnt  <= '0;
      duty_l   <= '0;
      duty_r   <= '0;
      dir_l    <= 1'b1;
      dir_r    <= 1'b1;
      pwm_l    <= 1'b0;
      pwm_r    <= 1'b0;
      moving   <= 1'b0;
      cmd_err  <= 1'b0;
      status_q <= ST_STOP;
    end else begin
      cmd_q    <= {en, TL, TR, F};
      presc    <= tick ? '0 : presc + 1'b1;
      pwm_cnt  <= tick ? pwm_cnt + 1'b1 : pwm_cnt;
      duty_l   <= duty_l_n[PWM_BITS-1:0];
      duty_r   <= duty_r_n[PWM_BITS-1:0];
      dir_l    <= dir_l_n;
      dir_r    <= dir_r_n;
      pwm_l    <= (duty_l > pwm_cnt);
      pwm_r    <= (duty_r > pwm_cnt);
      moving   <= (duty_l_n != '0) || (duty_r_n != '0);
      cmd_err  <= illegal;
      status_q <= status_n;
    end
  end

  assign status = status_q;

endmodule
